// File: rtl/output_channel_pkg.sv
// Shared constants and types for the wormhole output channel.
package output_channel_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } oc_state_t;

endpackage

// File: rtl/output_channel_q_flit_fifo.sv
// Synchronous flit queue; head word reads as zero while empty.
module flit_fifo
    import output_channel_pkg::*;
#(
    parameter int unsigned W     = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/output_channel_q.sv
// Wormhole output channel: arbitrates inputs, locks owner until tail, queues flits.
module output_channel_q
    import output_channel_pkg::*;
#(
    parameter int unsigned IN_N       = 5,
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned ARB_TYPE   = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IN_N-1:0]          req_i,
    input  logic [IN_N-1:0]          data_vld_i,
    input  logic [IN_N-1:0]          flit_id_is_tail_i,
    input  logic [IN_N*DATA_W-1:0]   ic_data_i,
    output logic [IN_N-1:0]          grant_o,
    output logic [IN_N-1:0]          ic_rdy_o,
    output logic [DATA_W-1:0]        oc_data_o,
    output logic                     oc_tail_o,
    output logic                     oc_vld_o,
    input  logic                     oc_rdy_i
);

    localparam int unsigned OW = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int unsigned FW = DATA_W + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    oc_state_t         state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [IN_N-1:0]   grant_q, grant_d;

    logic              win_found;
    logic [OW-1:0]     win_idx;
    logic              fifo_full, fifo_empty, q_full;
    logic [CW-1:0]     fifo_count;
    logic              push, own_tail;
    logic [DATA_W-1:0] own_data;
    logic [FW-1:0]     head;

    // Winner search; iterating downward leaves the highest-priority hit last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (ARB_TYPE == ARB_FIXED) begin
            for (int i = int'(IN_N) - 1; i >= 0; i--) begin
                if (req_i[OW'(i)]) begin
                    win_found = 1'b1;
                    win_idx   = OW'(i);
                end
            end
        end else begin
            for (int k = int'(IN_N) - 1; k >= 0; k--) begin
                int j;
                j = int'(ptr_q) + k;
                if (j >= int'(IN_N)) j = j - int'(IN_N);
                if (req_i[OW'(j)]) begin
                    win_found = 1'b1;
                    win_idx   = OW'(j);
                end
            end
        end
    end

    assign q_full   = (fifo_count == CW'(FIFO_DEPTH));
    assign own_tail = flit_id_is_tail_i[owner_q];
    assign own_data = ic_data_i[int'(owner_q) * DATA_W +: DATA_W];
    assign push     = grant_q[owner_q] & data_vld_i[owner_q] & ~fifo_full;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                    grant_d = IN_N'(1) << win_idx;
                    if (ARB_TYPE == ARB_RR)
                        ptr_d = (win_idx == OW'(IN_N - 1)) ? '0 : win_idx + OW'(1);
                end
            end
            LOCKED: begin
                if (push && own_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    flit_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (oc_rdy_i),
        .wdata_i ({own_tail, own_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign grant_o   = grant_q;
    assign ic_rdy_o  = grant_q & {IN_N{~q_full}};
    assign oc_vld_o  = ~fifo_empty;
    assign oc_tail_o = head[FW-1];
    assign oc_data_o = head[DATA_W-1:0];

endmodule

// File: tb/tb_output_channel_q.sv
// Directed bench: round-robin and fixed-priority instances share stimulus.
module tb_output_channel_q;
    import output_channel_pkg::*;

    localparam int unsigned IN_N   = 5;
    localparam int unsigned DATA_W = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [IN_N-1:0]        req, vld, tail;
    logic [IN_N*DATA_W-1:0] ic_data;
    logic                   oc_rdy;

    logic [IN_N-1:0]   g_rr, r_rr, g_fx, r_fx;
    logic [DATA_W-1:0] d_rr, d_fx;
    logic              t_rr, v_rr, t_fx, v_fx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    output_channel_q #(.IN_N(IN_N), .DATA_W(DATA_W), .ARB_TYPE(0), .FIFO_DEPTH(4)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_vld_i(vld),
        .flit_id_is_tail_i(tail), .ic_data_i(ic_data), .grant_o(g_rr),
        .ic_rdy_o(r_rr), .oc_data_o(d_rr), .oc_tail_o(t_rr), .oc_vld_o(v_rr),
        .oc_rdy_i(oc_rdy)
    );

    output_channel_q #(.IN_N(IN_N), .DATA_W(DATA_W), .ARB_TYPE(1), .FIFO_DEPTH(4)) u_fx (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_vld_i(vld),
        .flit_id_is_tail_i(tail), .ic_data_i(ic_data), .grant_o(g_fx),
        .ic_rdy_o(r_fx), .oc_data_o(d_fx), .oc_tail_o(t_fx), .oc_vld_o(v_fx),
        .oc_rdy_i(oc_rdy)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic [4:0]  vld;
        logic [4:0]  tail;
        logic [6:0]  dat;
        logic        ordy;
        logic [4:0]  eg;
        logic [4:0]  er;
        logic        ev;
        logic [9:0]  ed;
        logic        et;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Lane i carries {i, d} so the owner is visible in the output data.
    task automatic set_data(input logic [6:0] d);
        for (int i = 0; i < int'(IN_N); i++)
            ic_data[i*DATA_W +: DATA_W] = {3'(i), d};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] rcv [$];
        int          nxt;
        int          cyc;
        logic        pushed, popped;

        rst = 1'b1; req = '0; vld = '0; tail = '0; oc_rdy = 1'b0; ic_data = '0;

        //            rst   req     vld     tail    dat    ordy  eg      er      ev    ed       et
        tbl[0]  = '{1'b1, 5'h1f, 5'h1f, 5'h00, 7'h00, 1'b0, 5'h00, 5'h00, 1'b0, 10'h000, 1'b0};
        tbl[1]  = '{1'b0, 5'h00, 5'h00, 5'h00, 7'h00, 1'b1, 5'h00, 5'h00, 1'b0, 10'h000, 1'b0};
        tbl[2]  = '{1'b0, 5'h00, 5'h00, 5'h00, 7'h00, 1'b1, 5'h00, 5'h00, 1'b0, 10'h000, 1'b0};
        tbl[3]  = '{1'b0, 5'h0a, 5'h00, 5'h00, 7'h00, 1'b1, 5'h02, 5'h02, 1'b0, 10'h000, 1'b0};
        tbl[4]  = '{1'b0, 5'h0a, 5'h0a, 5'h00, 7'h11, 1'b1, 5'h02, 5'h02, 1'b1, 10'h091, 1'b0};
        tbl[5]  = '{1'b0, 5'h0a, 5'h0a, 5'h00, 7'h12, 1'b1, 5'h02, 5'h02, 1'b1, 10'h092, 1'b0};
        tbl[6]  = '{1'b0, 5'h0a, 5'h0a, 5'h0a, 7'h13, 1'b1, 5'h00, 5'h00, 1'b1, 10'h093, 1'b1};
        tbl[7]  = '{1'b0, 5'h0a, 5'h00, 5'h00, 7'h00, 1'b1, 5'h08, 5'h08, 1'b0, 10'h000, 1'b0};
        tbl[8]  = '{1'b0, 5'h0a, 5'h0a, 5'h00, 7'h21, 1'b1, 5'h08, 5'h08, 1'b1, 10'h1a1, 1'b0};
        tbl[9]  = '{1'b0, 5'h0a, 5'h0a, 5'h0a, 7'h22, 1'b1, 5'h00, 5'h00, 1'b1, 10'h1a2, 1'b1};
        tbl[10] = '{1'b0, 5'h0a, 5'h00, 5'h00, 7'h00, 1'b1, 5'h02, 5'h02, 1'b0, 10'h000, 1'b0};

        // Reset, idle, then round-robin 1,3,1 with bubbles between packets.
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; vld = tbl[i].vld;
            tail = tbl[i].tail; oc_rdy = tbl[i].ordy; set_data(tbl[i].dat);
            tick();
            chk($sformatf("v%0d_grant", i),  32'(g_rr), 32'(tbl[i].eg));
            chk($sformatf("v%0d_ic_rdy", i), 32'(r_rr), 32'(tbl[i].er));
            chk($sformatf("v%0d_oc_vld", i), 32'(v_rr), 32'(tbl[i].ev));
            chk($sformatf("v%0d_oc_data", i), 32'(d_rr), 32'(tbl[i].ed));
            chk($sformatf("v%0d_oc_tail", i), 32'(t_rr), 32'(tbl[i].et));
        end

        // Back-pressure: owner 1 sends 6 flits into a stalled depth-4 queue.
        req = '0; vld = 5'b00010; tail = '0; oc_rdy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            set_data(7'(8'h30 + n));
            tick();
        end
        chk("bp_full_ic_rdy", 32'(r_rr), 32'h0);
        chk("bp_grant", 32'(g_rr), 32'h02);
        chk("bp_head", 32'(d_rr), 32'h0b0);
        set_data(7'h34);
        tick();
        chk("bp_hold_head", 32'(d_rr), 32'h0b0);
        chk("bp_hold_ic_rdy", 32'(r_rr), 32'h0);

        nxt = 4; cyc = 0; oc_rdy = 1'b1;
        while (rcv.size() < 6 && cyc < 40) begin
            vld  = (nxt < 6) ? 5'b00010 : 5'b00000;
            tail = (nxt == 5) ? 5'b00010 : 5'b00000;
            set_data(7'(8'h30 + nxt));
            pushed = r_rr[1] & vld[1];
            popped = v_rr & oc_rdy;
            if (popped) rcv.push_back({t_rr, d_rr});
            tick();
            if (pushed) nxt++;
            cyc++;
        end
        chk("bp_received_count", 32'(rcv.size()), 32'd6);
        for (int n = 0; n < 6 && n < rcv.size(); n++)
            chk($sformatf("bp_flit%0d", n), 32'(rcv[n]), 32'({(n == 5), 10'(128 + 8'h30 + n)}));
        chk("bp_release_grant", 32'(g_rr), 32'h0);
        chk("bp_drained", 32'(v_rr), 32'h0);

        // Single-flit packet from input 0 (pointer is at 2).
        vld = '0; tail = '0; req = 5'b00001;
        tick();
        chk("sf_grant", 32'(g_rr), 32'h01);
        req = '0; vld = 5'b00001; tail = 5'b00001; set_data(7'h40);
        tick();
        chk("sf_release", 32'(g_rr), 32'h0);
        chk("sf_tail", 32'(t_rr), 32'h1);
        chk("sf_data", 32'(d_rr), 32'h040);
        vld = '0; tail = '0;
        tick();
        chk("sf_stays_idle", 32'(g_rr), 32'h0);

        // Input 2 holds a 4-flit lock while input 0 toggles its request.
        req = 5'b00100;
        tick();
        chk("lk_grant", 32'(g_rr), 32'h04);
        for (int n = 0; n < 4; n++) begin
            req  = (n % 2 == 1) ? 5'b00101 : 5'b00100;
            vld  = 5'b00100;
            tail = (n == 3) ? 5'b00100 : 5'b00000;
            set_data(7'(8'h50 + n));
            tick();
            chk($sformatf("lk_grant_f%0d", n), 32'(g_rr), (n < 3) ? 32'h04 : 32'h0);
        end
        req = '0; vld = '0; tail = '0;
        tick();
        tick();

        // Reset mid-packet: pointer is at 3, then back to 0 after reset.
        req = 5'b00010;
        tick();
        chk("rm_grant", 32'(g_rr), 32'h02);
        req = '0; oc_rdy = 1'b0; vld = 5'b00010; set_data(7'h60);
        tick();
        set_data(7'h61);
        tick();
        chk("rm_partial_vld", 32'(v_rr), 32'h1);
        rst = 1'b1;
        tick();
        chk("rm_grant_clr", 32'(g_rr), 32'h0);
        chk("rm_ic_rdy_clr", 32'(r_rr), 32'h0);
        chk("rm_vld_clr", 32'(v_rr), 32'h0);
        chk("rm_data_clr", 32'(d_rr), 32'h0);
        chk("rm_tail_clr", 32'(t_rr), 32'h0);
        rst = 1'b0; vld = '0; req = 5'b01010;
        tick();
        chk("rm_ptr0_grant", 32'(g_rr), 32'h02);

        // Fixed priority: input 1 always beats 2 and 4.
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0; req = 5'b10110; vld = 5'b10110; tail = 5'b10110;
        oc_rdy = 1'b1; set_data(7'h55);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("fx_grant_c%0d", c), 32'(g_fx), (c % 2 == 1) ? 32'h02 : 32'h0);
            if (c == 2) chk("fx_data", 32'(d_fx), 32'h0d5);
        end
        req = '0; vld = '0; tail = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
